ps2_rx_frontend: RTL and testbench

PS/2 keyboard receive front end for the ps2_keyboard AXI4-Lite peripheral. Synchronizes and deglitches the raw PS/2 clock/data lines, deserializes 11-bit device-to-host frames, validates start, parity and stop bits, and folds the E0/F0 prefix bytes into a make/break/extended key event. Completed events are buffered in a small FIFO and drained by the AXI slave register block through a valid/ready handshake.

---
 rtl/ps2_rx_frontend.sv | 210 +++++++++++++++++++++
 tb/tb_ps2_rx_frontend.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_frontend.sv
// PS/2 device-to-host receive front end: pin conditioning, frame deserializer,
// E0/F0 prefix folding and a small event FIFO drained by a valid/ready consumer.
module ps2_rx_frontend #(
  parameter int CLK_FREQ_HZ    = 100000000,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       s00_axi_aclk,
  input  logic       s00_axi_aresetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       frame_err,
  output logic       overflow,
  output logic [7:0] err_count
);

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 2);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK
  } rx_state_t;

  // CLK_FREQ_HZ is informational only; this keeps it referenced.
  logic unused_params;
  assign unused_params = ^CLK_FREQ_HZ;

  logic [1:0]      clk_sync;
  logic [1:0]      data_sync;
  logic            clk_filt;
  logic            clk_filt_d;
  logic [3:0]      filt_cnt;
  logic            fall_stb;
  logic            rx_bit;

  rx_state_t       state;
  rx_state_t       state_nxt;
  logic [9:0]      shift_reg;
  logic [3:0]      bit_cnt;
  logic [TO_W-1:0] idle_cnt;
  logic            frame_good;
  logic            frame_bad;

  logic [7:0]      rx_byte;
  logic            ext_flag;
  logic            brk_flag;
  logic            push_req;
  logic [9:0]      push_word;

  logic [9:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_nxt;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             fifo_full;
  logic             do_push;
  logic             do_pop;

  // The filtered clock only follows the synchronized pin after FILTER_LEN agreeing samples.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      data_sync  <= {data_sync[0], ps2_data};
      clk_filt_d <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == 4'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end
  end

  assign fall_stb = clk_filt_d & ~clk_filt;
  assign rx_bit   = data_sync[1];
  assign rx_byte  = shift_reg[7:0];

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) state <= S_IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall_stb && !rx_bit) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (idle_cnt == TO_W'(TIMEOUT_CYCLES)) begin
          state_nxt = S_IDLE;
          frame_bad = 1'b1;
        end else if (fall_stb && bit_cnt == 4'd9) begin
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        state_nxt = S_IDLE;
        // shift_reg holds {stop, parity, data[7:0]}; odd parity over data+parity
        if ((^shift_reg[8:0]) && shift_reg[9]) frame_good = 1'b1;
        else                                   frame_bad  = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bits arrive LSB first and are shifted in from the top of a 10-bit register.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
    end else if (state == S_SHIFT) begin
      if (fall_stb) begin
        shift_reg <= {rx_bit, shift_reg[9:1]};
        bit_cnt   <= bit_cnt + 4'd1;
        idle_cnt  <= '0;
      end else begin
        idle_cnt  <= idle_cnt + TO_W'(1);
      end
    end else begin
      bit_cnt  <= '0;
      idle_cnt <= '0;
    end
  end

  assign push_req  = frame_good && (rx_byte != 8'hE0) && (rx_byte != 8'hF0);
  assign push_word = {ext_flag, brk_flag, rx_byte};

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      frame_err <= frame_bad;
      if (frame_bad) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end else if (frame_good) begin
        if (rx_byte == 8'hE0) begin
          ext_flag <= 1'b1;
        end else if (rx_byte == 8'hF0) begin
          brk_flag <= 1'b1;
        end else begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    do_pop    = key_valid && key_ready;
    fifo_full = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    do_push   = push_req && (!fifo_full || do_pop);
    rd_nxt    = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    cnt_nxt   = fifo_cnt + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Head outputs are registered from the post-edge read pointer, forwarding a word
  // written into the slot that becomes the head in the same edge.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fifo_cnt  <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (do_push) begin
        fifo_mem[wr_ptr] <= push_word;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      rd_ptr    <= rd_nxt;
      fifo_cnt  <= cnt_nxt;
      key_valid <= (cnt_nxt != '0);
      overflow  <= push_req && !do_push;
      if (do_push && (wr_ptr == rd_nxt)) {key_ext, key_break, key_code} <= push_word;
      else                               {key_ext, key_break, key_code} <= fifo_mem[rd_nxt];
    end
  end

endmodule

// File: tb/tb_ps2_rx_frontend.sv
// Scoreboard bench for ps2_rx_frontend: a frame-level model predicts key events,
// error and overflow counts; a forked monitor pops and compares on every handshake.
module tb_ps2_rx_frontend;

  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 300;
  localparam int FIFO_DEPTH     = 4;
  localparam int HALF           = 40;
  // Raw stop-bit fall to FIFO write edge: 2 sync + FILTER_LEN filter + strobe + CHECK.
  localparam int PUSH_EDGE      = 2 + FILTER_LEN + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic       frame_err;
  logic       overflow;
  logic [7:0] err_count;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [9:0] exp_q[$];
  bit         m_ext, m_brk;
  int         exp_err_cnt = 0;
  int         exp_errs = 0;
  int         exp_ovf = 0;
  int         err_seen = 0;
  int         ovf_seen = 0;
  int         stop_fall_cyc = 0;
  int         valid_rise_cyc = -1;
  bit         prev_valid = 1'b0;

  ps2_rx_frontend #(
    .CLK_FREQ_HZ   (100000000),
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rst_n),
    .ps2_clk        (ps2_clk),
    .ps2_data       (ps2_data),
    .key_code       (key_code),
    .key_ext        (key_ext),
    .key_break      (key_break),
    .key_valid      (key_valid),
    .key_ready      (key_ready),
    .frame_err      (frame_err),
    .overflow       (overflow),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        continue;
      end
      if (frame_err) err_seen++;
      if (overflow) ovf_seen++;
      if (key_valid && !prev_valid) valid_rise_cyc = cyc;
      prev_valid = key_valid;
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_event actual=%h required=none", {key_ext, key_break, key_code});
        end else begin
          e = exp_q.pop_front();
          check_output("event", {22'd0, key_ext, key_break, key_code}, {22'd0, e});
        end
      end
    end
  endtask

  // Frame-level reference: prefix bytes set flags, bad frames clear them and count.
  task automatic model_frame(input logic [7:0] b, input bit good, input bit pop_on_push);
    if (!good) begin
      exp_errs++;
      if (exp_err_cnt < 255) exp_err_cnt++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (!key_ready && exp_q.size() >= FIFO_DEPTH && !pop_on_push) exp_ovf++;
      else exp_q.push_back({m_ext, m_brk, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic drive_bit(input bit v, input bit is_stop, input bit pop_pulse);
    ps2_data = v;
    tick(HALF);
    ps2_clk = 1'b0;
    if (is_stop) stop_fall_cyc = cyc;
    for (int i = 1; i <= HALF; i++) begin
      tick(1);
      if (pop_pulse) key_ready = (i == PUSH_EDGE - 1);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                                input int nbits, input bit pop_on_push);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    model_frame(b, (nbits == 11) && !bad_par && !bad_stop, pop_on_push);
    for (int i = 0; i < nbits; i++) drive_bit(f[i], i == 10, pop_on_push && i == 10);
    ps2_data = 1'b1;
    tick(HALF);
    if (nbits < 11) tick(TIMEOUT_CYCLES + 60);
  endtask

  task automatic glitches(input int n);
    for (int k = 0; k < n; k++) begin
      ps2_clk = 1'b0;
      tick($urandom_range(1, FILTER_LEN - 1));
      ps2_clk = 1'b1;
      tick(3);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    check_output("drain_pending", exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_code"}, key_code, 0);
    check_output({tag, "_ext"}, key_ext, 0);
    check_output({tag, "_break"}, key_break, 0);
    check_output({tag, "_valid"}, key_valid, 0);
    check_output({tag, "_frame_err"}, frame_err, 0);
    check_output({tag, "_overflow"}, overflow, 0);
    check_output({tag, "_err_count"}, err_count, 0);
  endtask

  initial begin
    logic [10:0] part;
    int lat;
    rst_n     = 1'b0;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    key_ready = 1'b1;
    fork
      monitor();
    join_none
    tick(5);
    check_reset_values("reset");
    rst_n = 1'b1;
    tick(10);

    $display("[TB] single frame 0x1C with latency");
    valid_rise_cyc = -1;
    apply_stimulus(8'h1C, 0, 0, 11, 0);
    wait_drain();
    lat = valid_rise_cyc - stop_fall_cyc;
    checks++;
    if (lat < PUSH_EDGE - 1 || lat > PUSH_EDGE + 1) begin
      errors++;
      $display("[TB] FAIL latency actual=%0d required=%0d..%0d", lat, PUSH_EDGE - 1, PUSH_EDGE + 1);
    end
    check_output("no_err_pulse", err_seen, exp_errs);

    $display("[TB] prefix sequences");
    apply_stimulus(8'hE0, 0, 0, 11, 0);
    apply_stimulus(8'hF0, 0, 0, 11, 0);
    apply_stimulus(8'h75, 0, 0, 11, 0);
    apply_stimulus(8'hF0, 0, 0, 11, 0);
    apply_stimulus(8'h1C, 0, 0, 11, 0);
    wait_drain();

    $display("[TB] parity and stop errors");
    apply_stimulus(8'h1C, 1, 0, 11, 0);
    apply_stimulus(8'h1C, 0, 0, 11, 0);
    wait_drain();
    check_output("err_count_parity", err_count, exp_err_cnt);
    apply_stimulus(8'h1C, 0, 1, 11, 0);
    check_output("err_count_stop", err_count, exp_err_cnt);
    check_output("err_pulses", err_seen, exp_errs);

    $display("[TB] timeout clears prefix");
    apply_stimulus(8'hE0, 0, 0, 11, 0);
    apply_stimulus(8'h6B, 0, 0, 5, 0);
    apply_stimulus(8'h29, 0, 0, 11, 0);
    wait_drain();
    check_output("err_count_timeout", err_count, exp_err_cnt);
    check_output("err_pulses_timeout", err_seen, exp_errs);

    $display("[TB] overflow and full push/pop");
    key_ready = 1'b0;
    for (int b = 1; b <= FIFO_DEPTH + 1; b++) apply_stimulus(8'(b), 0, 0, 11, 0);
    check_output("overflow_pulses", ovf_seen, exp_ovf);
    check_output("full_valid", key_valid, 1);
    check_output("head_held", {22'd0, key_ext, key_break, key_code}, {22'd0, exp_q[0]});
    apply_stimulus(8'h06, 0, 0, 11, 1);
    check_output("overflow_push_pop", ovf_seen, exp_ovf);
    key_ready = 1'b1;
    wait_drain();

    $display("[TB] reset mid-frame with glitches");
    key_ready = 1'b0;
    apply_stimulus(8'h33, 0, 0, 11, 0);
    part = {1'b1, ~^8'h5A, 8'h5A, 1'b0};
    for (int i = 0; i < 6; i++) drive_bit(part[i], 0, 0);
    rst_n = 1'b0;
    ps2_data = 1'b0;
    glitches(4);
    check_reset_values("midframe_reset");
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    exp_err_cnt = 0;
    rst_n = 1'b1;
    tick(5);
    glitches(10);
    ps2_data = 1'b1;
    tick(20);
    check_output("glitch_no_valid", key_valid, 0);
    key_ready = 1'b1;
    apply_stimulus(8'h4D, 0, 0, 11, 0);
    wait_drain();
    check_output("glitch_err_count", err_count, exp_err_cnt);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 25; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      b = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom);
      apply_stimulus(b, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, 11, 0);
    end
    wait_drain();
    check_output("final_err_count", err_count, exp_err_cnt);
    check_output("final_err_pulses", err_seen, exp_errs);
    check_output("final_overflow", ovf_seen, exp_ovf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
